input_debounce_array: RTL and testbench

//  Multi-channel synchronise-and-debounce front end for asynchronous slow inputs.

---
 rtl/input_debounce_array_pkg.sv | 20 ++
 rtl/input_debounce_array_channel.sv | 84 ++++++++
 rtl/input_debounce_array.sv | 35 +++
 tb/tb_input_debounce_array.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/input_debounce_array_pkg.sv
// rtl/input_debounce_array_pkg.sv - shared width helpers for counter blocks
package input_debounce_array_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Width needed to hold 0..max_count, never narrower than one bit
  function automatic int cnt_width(input int max_count);
    int w;
    w = clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/input_debounce_array_channel.sv
// rtl/input_debounce_array_channel.sv - one synchronise-and-debounce channel
module input_debounce_array_channel
  import input_debounce_array_pkg::*;
#(
  parameter int   SYNC_STAGES  = 2,
  parameter int   DEBOUNCE_CNT = 2,
  parameter logic RST_VAL_BIT  = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  input  logic i_bypass,
  output logic o_db,
  output logic o_rise,
  output logic o_fall,
  output logic o_glitch
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   db_d;
  logic                   rise_d;
  logic                   fall_d;
  logic                   glitch_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL_BIT}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // cnt counts consecutive cycles the synchronised level has disagreed with o_db
  always_comb begin
    db_d     = o_db;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    if (i_bypass) begin
      db_d   = s;
      cnt_d  = '0;
      rise_d = s & ~o_db;
      fall_d = ~s & o_db;
    end else if (s == o_db) begin
      if (cnt_q != '0) begin
        cnt_d    = '0;
        glitch_d = 1'b1;
      end
    end else if (cnt_q == CNT_LAST) begin
      db_d   = s;
      cnt_d  = '0;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_db     <= RST_VAL_BIT;
      cnt_q    <= '0;
      o_rise   <= 1'b0;
      o_fall   <= 1'b0;
      o_glitch <= 1'b0;
    end else begin
      o_db     <= db_d;
      cnt_q    <= cnt_d;
      o_rise   <= rise_d;
      o_fall   <= fall_d;
      o_glitch <= glitch_d;
    end
  end

endmodule

// File: rtl/input_debounce_array.sv
// rtl/input_debounce_array.sv - multi-channel synchronise-and-debounce front end
module input_debounce_array #(
  parameter int                NUM_CH       = 3,
  parameter int                SYNC_STAGES  = 2,
  parameter int                DEBOUNCE_CNT = 2,
  parameter logic [NUM_CH-1:0] RST_VAL      = 3'b100
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_raw,
  input  logic [NUM_CH-1:0] i_bypass,
  output logic [NUM_CH-1:0] o_db,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic [NUM_CH-1:0] o_glitch
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    input_debounce_array_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .RST_VAL_BIT  (RST_VAL[i])
    ) u_channel (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_raw    (i_raw[i]),
      .i_bypass (i_bypass[i]),
      .o_db     (o_db[i]),
      .o_rise   (o_rise[i]),
      .o_fall   (o_fall[i]),
      .o_glitch (o_glitch[i])
    );
  end

endmodule

// File: tb/tb_input_debounce_array.sv
// tb/tb_input_debounce_array.sv - self-checking bench for input_debounce_array
module tb_input_debounce_array;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] raw_a = 3'b000, byp_a = 3'b000;
  logic [2:0] db_a, rise_a, fall_a, gl_a;
  logic [2:0] raw_b = 3'b000, byp_b = 3'b000;
  logic [2:0] db_b, rise_b, fall_b, gl_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  input_debounce_array dut_a (
    .i_clk(clk), .i_rst(rst), .i_raw(raw_a), .i_bypass(byp_a),
    .o_db(db_a), .o_rise(rise_a), .o_fall(fall_a), .o_glitch(gl_a)
  );

  input_debounce_array #(
    .NUM_CH(3), .SYNC_STAGES(3), .DEBOUNCE_CNT(5), .RST_VAL(3'b000)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_raw(raw_b), .i_bypass(byp_b),
    .o_db(db_b), .o_rise(rise_b), .o_fall(fall_b), .o_glitch(gl_b)
  );

  typedef struct {
    logic       rst;
    logic [2:0] raw;
    logic [2:0] byp;
    logic [2:0] db;
    logic [2:0] rise;
    logic [2:0] fall;
    logic [2:0] gl;
  } vec_t;

  vec_t tbl[$];

  // Reference model: sync is a pure delay line of raw samples, debounce tracks
  // how long the delayed level has disagreed with the accepted level.
  int         ss[2] = '{2, 3};
  int         dc[2] = '{2, 5};
  logic [2:0] rv[2] = '{3'b100, 3'b000};
  logic       hist[2][3][$];
  int         run[2][3];
  logic [2:0] m_db[2], m_rise[2], m_fall[2], m_gl[2];

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic add(input logic r, input logic [2:0] rw, input logic [2:0] bp,
                     input logic [2:0] d, input logic [2:0] ri, input logic [2:0] fa,
                     input logic [2:0] g);
    vec_t v;
    v.rst = r; v.raw = rw; v.byp = bp; v.db = d; v.rise = ri; v.fall = fa; v.gl = g;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_db[d] = rv[d];
      m_rise[d] = '0; m_fall[d] = '0; m_gl[d] = '0;
      for (int c = 0; c < 3; c++) begin
        hist[d][c].delete();
        for (int k = 0; k < ss[d]; k++) hist[d][c].push_back(rv[d][c]);
        run[d][c] = 0;
      end
    end
  endtask

  task automatic model_step();
    logic [2:0] rws, bps;
    logic s;
    for (int d = 0; d < 2; d++) begin
      rws = (d == 0) ? raw_a : raw_b;
      bps = (d == 0) ? byp_a : byp_b;
      m_rise[d] = '0; m_fall[d] = '0; m_gl[d] = '0;
      for (int c = 0; c < 3; c++) begin
        s = hist[d][c].pop_front();
        hist[d][c].push_back(rws[c]);
        if (bps[c]) begin
          if (s != m_db[d][c]) begin
            m_rise[d][c] = s;
            m_fall[d][c] = ~s;
          end
          m_db[d][c] = s;
          run[d][c] = 0;
        end else if (s == m_db[d][c]) begin
          m_gl[d][c] = (run[d][c] > 0);
          run[d][c] = 0;
        end else begin
          run[d][c]++;
          if (run[d][c] == dc[d]) begin
            m_db[d][c] = s;
            m_rise[d][c] = s;
            m_fall[d][c] = ~s;
            run[d][c] = 0;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  initial begin
    // rst raw byp | db rise fall glitch  (dut_a, 2 sync stages, count 2)
    add(1, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000);
    add(1, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000);
    add(0, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000);
    add(0, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000);
    add(0, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000);
    add(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000);
    for (int k = 0; k < 6; k++) add(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000);
    add(0, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000);
    add(0, 3'b011, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b010);
    add(0, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
    add(0, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
    add(0, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
    add(0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000);
    add(0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    add(0, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000);
    add(0, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
    add(0, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000);
    add(0, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    add(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; raw_a = tbl[i].raw; byp_a = tbl[i].byp;
      tick();
      chk($sformatf("tbl%0d_db", i), db_a, tbl[i].db);
      chk($sformatf("tbl%0d_rise", i), rise_a, tbl[i].rise);
      chk($sformatf("tbl%0d_fall", i), fall_a, tbl[i].fall);
      chk($sformatf("tbl%0d_glitch", i), gl_a, tbl[i].gl);
    end

    // Clean step on the deep configuration: 3 sync stages + count 5 = 8 edges
    raw_b = 3'b001;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 7) chk("b_step_db_e7", db_b, 3'b000);
      if (k == 8) begin
        chk("b_step_db_e8", db_b, 3'b001);
        chk("b_step_rise_e8", rise_b, 3'b001);
      end
      if (k == 9) chk("b_step_rise_e9", rise_b, 3'b000);
    end

    // Bypass asserted after one counted cycle on dut_a
    raw_a = 3'b001;
    repeat (3) tick();
    chk("a_midcnt_db_pre", db_a, 3'b000);
    byp_a = 3'b001;
    tick();
    chk("a_midcnt_db", db_a, 3'b001);
    chk("a_midcnt_rise", rise_a, 3'b001);
    chk("a_midcnt_glitch", gl_a, 3'b000);
    byp_a = 3'b000;
    tick();
    chk("a_midcnt_rise_clr", rise_a, 3'b000);
    raw_a = 3'b000;
    repeat (6) tick();
    chk("a_return_db", db_a, 3'b000);

    // Bypass mid-count on dut_b: accepted long before the 5-cycle count would be
    raw_b = 3'b011;
    repeat (5) tick();
    chk("b_midcnt_db_pre", db_b, 3'b001);
    byp_b = 3'b010;
    tick();
    chk("b_midcnt_db", db_b, 3'b011);
    chk("b_midcnt_rise", rise_b, 3'b010);
    chk("b_midcnt_glitch", gl_b, 3'b000);
    byp_b = 3'b000;

    // Async reset in the middle of a ch1 count
    raw_a = 3'b010;
    repeat (3) tick();
    chk("a_rst_db_pre", db_a, 3'b000);
    #2 rst = 1'b1;
    #1;
    chk("a_rst_db_async", db_a, 3'b100);
    chk("a_rst_pulses", rise_a | fall_a | gl_a, 3'b000);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("a_rel_db_e3", db_a, 3'b100);
    chk("a_rel_rise_e3", rise_a, 3'b000);
    tick();
    chk("a_rel_db_e4", db_a, 3'b010);
    chk("a_rel_rise_e4", rise_a, 3'b010);
    chk("a_rel_fall_e4", fall_a, 3'b100);

    // Randomised run against the reference model on both configurations
    rst = 1'b1;
    raw_a = 3'($urandom); raw_b = 3'($urandom);
    byp_a = 3'b000; byp_b = 3'b000;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      chk("rnd_a_db", db_a, m_db[0]);
      chk("rnd_a_rise", rise_a, m_rise[0]);
      chk("rnd_a_fall", fall_a, m_fall[0]);
      chk("rnd_a_glitch", gl_a, m_gl[0]);
      chk("rnd_b_db", db_b, m_db[1]);
      chk("rnd_b_rise", rise_b, m_rise[1]);
      chk("rnd_b_fall", fall_b, m_fall[1]);
      chk("rnd_b_glitch", gl_b, m_gl[1]);
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 3) == 0) raw_a[c] = ~raw_a[c];
        if ($urandom_range(0, 5) == 0) raw_b[c] = ~raw_b[c];
        if ($urandom_range(0, 31) == 0) byp_a[c] = ~byp_a[c];
        if ($urandom_range(0, 31) == 0) byp_b[c] = ~byp_b[c];
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
